// File: rtl/inst_queue.sv
// In-order instruction FIFO between fetch/branch-predict and the issue unit.
// Buffers fetched instructions together with their PC and prediction info. The head entry is
// presented combinationally (show-ahead) so issue can decode it and pop it in the same cycle.
// A flush (mispredict/redirect) discards every entry.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   flush                    discard all entries (wins over push/pop, loses to reset)
//   if_we, if_inst, if_pc,   fetch push request and payload
//   if_pred_taken, if_pred_target
//   iq_full, iq_almost_full  registered occupancy flags towards fetch
//   iq_re                    issue pop request
//   iq_empty                 registered, no valid entry
//   iq_inst, iq_pc,          head entry payload, forced to 0 while empty
//   iq_pred_taken, iq_pred_target
//   iq_count                 occupancy 0..DEPTH
module inst_queue #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned AFULL_THR = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_we,
   input  logic [31:0]       if_inst,
   input  logic [31:0]       if_pc,
   input  logic              if_pred_taken,
   input  logic [31:0]       if_pred_target,
   output logic              iq_full,
   output logic              iq_almost_full,
   input  logic              iq_re,
   output logic              iq_empty,
   output logic [31:0]       iq_inst,
   output logic [31:0]       iq_pc,
   output logic              iq_pred_taken,
   output logic [31:0]       iq_pred_target,
   output logic [ADDR_W:0]   iq_count
);

   localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AfullC = (ADDR_W + 1)'(AFULL_THR);

   // Payload storage, intentionally not reset.
   logic [31:0] inst_q   [DEPTH];
   logic [31:0] pc_q     [DEPTH];
   logic        taken_q  [DEPTH];
   logic [31:0] target_q [DEPTH];

   logic [ADDR_W-1:0] head_q, tail_q;
   logic [ADDR_W:0]   count_q, count_d, free_d;
   logic              empty_q, full_q, afull_q;
   logic              push, pop;

   // Full check uses the registered flag, so a push while full is dropped even if a pop
   // happens in the same cycle.
   always_comb begin
      push    = if_we && !full_q;
      pop     = iq_re && !empty_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      free_d = DepthC - count_d;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == DepthC);
         afull_q <= (free_d <= AfullC);
      end
   end

   // A push in a flush cycle belongs to the wrong path and is not written.
   always_ff @(posedge clk) begin
      if (rst && !flush && push) begin
         inst_q[tail_q]   <= if_inst;
         pc_q[tail_q]     <= if_pc;
         taken_q[tail_q]  <= if_pred_taken;
         target_q[tail_q] <= if_pred_target;
      end
   end

   // No same-cycle bypass: a pushed entry is visible at the head from the next cycle.
   assign iq_inst        = empty_q ? '0   : inst_q[head_q];
   assign iq_pc          = empty_q ? '0   : pc_q[head_q];
   assign iq_pred_taken  = empty_q ? 1'b0 : taken_q[head_q];
   assign iq_pred_target = empty_q ? '0   : target_q[head_q];

   assign iq_empty       = empty_q;
   assign iq_full        = full_q;
   assign iq_almost_full = afull_q;
   assign iq_count       = count_q;

`ifndef SYNTHESIS
   // Occupancy must agree with the pointer distance; when full the pointers coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (count_q <= DepthC)
            else $error("inst_queue: count %0d exceeds depth", count_q);
         assert ((count_q == DepthC) ? (tail_q == head_q)
                                     : (count_q[ADDR_W-1:0] == ADDR_W'(tail_q - head_q)))
            else $error("inst_queue: count %0d inconsistent with pointers", count_q);
      end
   end
`endif

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        if_we;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        iq_full;
   logic        iq_almost_full;
   logic        iq_re;
   logic        iq_empty;
   logic [31:0] iq_inst;
   logic [31:0] iq_pc;
   logic        iq_pred_taken;
   logic [31:0] iq_pred_target;
   logic [4:0]  iq_count;

   int total = 0;
   int bad   = 0;

   inst_queue #(
      .DEPTH     (16),
      .ADDR_W    (4),
      .AFULL_THR (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .if_we          (if_we),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target),
      .iq_full        (iq_full),
      .iq_almost_full (iq_almost_full),
      .iq_re          (iq_re),
      .iq_empty       (iq_empty),
      .iq_inst        (iq_inst),
      .iq_pc          (iq_pc),
      .iq_pred_taken  (iq_pred_taken),
      .iq_pred_target (iq_pred_target),
      .iq_count       (iq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rs;
      logic        we;
      logic        re;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
      logic [4:0]  cnt;
      logic        emp;
      logic        ful;
      logic        af;
      logic [31:0] h_inst;
      logic [31:0] h_pc;
      logic        h_pt;
      logic [31:0] h_tgt;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic emp, input logic ful,
                            input logic af);
      chk({tag, ".count"}, 32'(iq_count), 32'(cnt));
      chk({tag, ".empty"}, 32'(iq_empty), 32'(emp));
      chk({tag, ".full"},  32'(iq_full),  32'(ful));
      chk({tag, ".afull"}, 32'(iq_almost_full), 32'(af));
   endtask

   task automatic drive(input logic rs, input logic fl, input logic we, input logic re,
                        input logic [31:0] inst, input logic [31:0] pc, input logic pt,
                        input logic [31:0] tgt);
      rst            = rs;
      flush          = fl;
      if_we          = we;
      iq_re          = re;
      if_inst        = inst;
      if_pc          = pc;
      if_pred_taken  = pt;
      if_pred_target = tgt;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_cnt;

      //        rs  we  re  inst          pc     pt  tgt           cnt emp ful af  h_inst        h_pc   h_pt h_tgt
      vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,       5'd0, 1'b1, 1'b0, 1'b0,
                  32'h0,        32'h0, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h00100093, 32'h0, 1'b0, 32'h0,       5'd1, 1'b0, 1'b0, 1'b0,
                  32'h00100093, 32'h0, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h00200113, 32'h4, 1'b1, 32'h1000,    5'd2, 1'b0, 1'b0, 1'b0,
                  32'h00100093, 32'h0, 1'b0, 32'h0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h00300193, 32'h8, 1'b0, 32'h0,       5'd3, 1'b0, 1'b0, 1'b0,
                  32'h00100093, 32'h0, 1'b0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0,       5'd2, 1'b0, 1'b0, 1'b0,
                  32'h00200113, 32'h4, 1'b1, 32'h1000};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0,       5'd1, 1'b0, 1'b0, 1'b0,
                  32'h00300193, 32'h8, 1'b0, 32'h0};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0,       5'd0, 1'b1, 1'b0, 1'b0,
                  32'h0,        32'h0, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0,       5'd0, 1'b1, 1'b0, 1'b0,
                  32'h0,        32'h0, 1'b0, 32'h0};

      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // Reset, push three, pop three, pop on empty.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].rs, 1'b0, vecs[i].we, vecs[i].re, vecs[i].inst, vecs[i].pc, vecs[i].pt,
               vecs[i].tgt);
         tick();
         chk_state($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].emp, vecs[i].ful,
                   vecs[i].af);
         chk($sformatf("vec%0d.inst", i), iq_inst, vecs[i].h_inst);
         chk($sformatf("vec%0d.pc", i), iq_pc, vecs[i].h_pc);
         chk($sformatf("vec%0d.pt", i), 32'(iq_pred_taken), 32'(vecs[i].h_pt));
         chk($sformatf("vec%0d.tgt", i), iq_pred_target, vecs[i].h_tgt);
      end

      // Fill to 16 starting from a non-zero head, so the tail wraps.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 32'h0);
         tick();
         exp_cnt = i + 1;
         chk_state($sformatf("fill%0d", i), exp_cnt, 1'b0, exp_cnt == 16, exp_cnt >= 14);
      end
      // Push while full is dropped.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD, 32'hDEAD, 1'b1, 32'hDEAD);
      tick();
      chk_state("drop", 16, 1'b0, 1'b1, 1'b1);
      chk("drop.pc", iq_pc, 32'h0);
      // Push+pop while full: only the pop happens.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hBEEF, 32'hBEEF, 1'b0, 32'h0);
      tick();
      chk_state("fullpp", 15, 1'b0, 1'b0, 1'b1);
      chk("fullpp.pc", iq_pc, 32'h4);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("drain%0d.pc", i), iq_pc, 32'(i * 4));
         chk($sformatf("drain%0d.inst", i), iq_inst, 32'h1000 + 32'(i));
         drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
         tick();
      end
      chk_state("drained", 0, 1'b1, 1'b0, 1'b0);
      chk("drained.pc", iq_pc, 32'h0);

      // Count 1 with simultaneous push and pop, many times round the ring.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h3C, 32'h3C, 1'b0, 32'h0);
      tick();
      for (int k = 0; k < 40; k++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h2000 + 32'(k), 32'h40 + 32'(k * 4), k[0], 32'(k));
         tick();
         chk($sformatf("pp%0d.count", k), 32'(iq_count), 32'd1);
         chk($sformatf("pp%0d.pc", k), iq_pc, 32'h40 + 32'(k * 4));
         chk($sformatf("pp%0d.pt", k), 32'(iq_pred_taken), 32'(k[0]));
      end

      // Grow to 10, then flush with push and pop requested.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500 + 32'(i * 4), 1'b0, 32'h0);
         tick();
      end
      chk_state("pre_flush", 10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h999, 32'h999, 1'b1, 32'h999);
      tick();
      chk_state("flush", 0, 1'b1, 1'b0, 1'b0);
      chk("flush.pc", iq_pc, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      chk_state("post_flush", 0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hABCD, 32'h100, 1'b1, 32'h200);
      tick();
      chk_state("redirect", 1, 1'b0, 1'b0, 1'b0);
      chk("redirect.inst", iq_inst, 32'hABCD);
      chk("redirect.pc", iq_pc, 32'h100);
      chk("redirect.pt", 32'(iq_pred_taken), 32'd1);
      chk("redirect.tgt", iq_pred_target, 32'h200);

      // Grow to 5, then reset while pushing.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600 + 32'(i * 4), 1'b0, 32'h0);
         tick();
      end
      chk_state("pre_rst", 5, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h777, 1'b0, 32'h0);
      tick();
      chk_state("rst", 0, 1'b1, 1'b0, 1'b0);
      chk("rst.pc", iq_pc, 32'h0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 1'b0, 32'h0);
      tick();
      chk_state("resume", 1, 1'b0, 1'b0, 1'b0);
      chk("resume.pc", iq_pc, 32'h700);
      // Head is stable while iq_re is low.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      chk("stall.pc", iq_pc, 32'h700);
      chk_state("stall", 1, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
